// File: rtl/alu_cmd_master.sv
// alu_cmd_master: host-side initiator of the UART ALU command protocol.
// It captures operands and an opcode on i_start, then sends the bytes
// 01 A 02 B 03 op 00 one at a time, handshaking each byte with i_tx_done.
// After the last byte it waits for the result byte from the receiver.
// Optional feature: define ALU_CMD_MASTER_TIMEOUT_EN to compile in a response
// watchdog. With the watchdog, the wait for the result gives up after
// TIMEOUT_CYCLES clock cycles.
module alu_cmd_master #(
    parameter int NB_DATA        = 8,
    parameter int NB_ALU_OP      = 6,
    parameter int NB_TIMEOUT     = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_DATA-1:0]   i_A,
    input  logic [NB_DATA-1:0]   i_B,
    input  logic [NB_ALU_OP-1:0] i_op,
    output logic                 o_tx_start,
    output logic [NB_DATA-1:0]   o_tx_data,
    input  logic                 i_tx_done,
    input  logic [NB_DATA-1:0]   i_rx_data,
    input  logic                 i_rx_done,
    output logic                 o_busy,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_done,
    output logic                 o_timeout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] TX_WAIT = 2'd2;
    localparam logic [1:0] RX_WAIT = 2'd3;

    localparam logic [2:0] LAST_IDX = 3'd6;

    // Reject parameter sets where the opcode cannot be zero-extended into a byte
    // or the watchdog terminal count does not fit the counter.
    if (NB_DATA < NB_ALU_OP || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > (64'd1 << NB_TIMEOUT)) begin : g_bad_params
        $error("alu_cmd_master: inconsistent parameters");
    end

    logic [1:0]           state_q, state_d;
    logic [2:0]           idx_q, idx_d;
    logic [NB_DATA-1:0]   a_q, a_d;
    logic [NB_DATA-1:0]   b_q, b_d;
    logic [NB_ALU_OP-1:0] op_q, op_d;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [NB_DATA-1:0]   result_q, result_d;
    logic                 done_q, done_d;
    logic                 timeout_q, timeout_d;
    logic [NB_DATA-1:0]   cur_byte;

`ifdef ALU_CMD_MASTER_TIMEOUT_EN
    localparam logic [NB_TIMEOUT-1:0] TERM_COUNT = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);
    logic [NB_TIMEOUT-1:0] cnt_q, cnt_d;
`endif

    // Select the protocol byte for the current index from the captured operands.
    always_comb begin
        cur_byte = '0;
        case (idx_q)
            3'd0:    cur_byte = NB_DATA'(8'h01);
            3'd1:    cur_byte = a_q;
            3'd2:    cur_byte = NB_DATA'(8'h02);
            3'd3:    cur_byte = b_q;
            3'd4:    cur_byte = NB_DATA'(8'h03);
            3'd5:    cur_byte = NB_DATA'(op_q);
            3'd6:    cur_byte = NB_DATA'(8'h00);
            default: cur_byte = '0;
        endcase
    end

    // Next-state logic: the transaction sequencer plus the registered output pulses.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        result_d   = result_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    a_d     = i_A;
                    b_d     = i_B;
                    op_d    = i_op;
                    idx_d   = 3'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = cur_byte;
                state_d    = TX_WAIT;
            end
            TX_WAIT: begin
                if (i_tx_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = RX_WAIT;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = SEND;
                    end
                end
            end
            RX_WAIT: begin
                if (i_rx_done) begin
                    result_d = i_rx_data;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
                else if (cnt_q == TERM_COUNT) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            result_q   <= '0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            result_q   <= result_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;
    assign o_result   = result_q;
    assign o_done     = done_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_alu_cmd_master.sv
// tb_alu_cmd_master: directed-vector bench for alu_cmd_master.
// Expected bytes and results are hand-derived from the protocol.
// The watchdog scenario is selected by ALU_CMD_MASTER_TIMEOUT_EN.
module tb_alu_cmd_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] aIn;
    logic [7:0] bIn;
    logic [5:0] opIn;
    logic       txStart;
    logic [7:0] txData;
    logic       txDone;
    logic [7:0] rxData;
    logic       rxDone;
    logic       busy;
    logic [7:0] result;
    logic       done;
    logic       timeout;

    int vectorCount   = 0;
    int miscompares   = 0;
    int txStartCount  = 0;
    int doneCount     = 0;
    int timeoutCount  = 0;
    int bothSeen      = 0;
    logic [7:0] lastResult = 8'h00;

    alu_cmd_master #(
        .NB_DATA(8),
        .NB_ALU_OP(6),
        .NB_TIMEOUT(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_start(start),
        .i_A(aIn),
        .i_B(bIn),
        .i_op(opIn),
        .o_tx_start(txStart),
        .o_tx_data(txData),
        .i_tx_done(txDone),
        .i_rx_data(rxData),
        .i_rx_done(rxDone),
        .o_busy(busy),
        .o_result(result),
        .o_done(done),
        .o_timeout(timeout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count output pulses as seen in the cycle that just ended.
    always @(posedge clk) begin
        if (txStart) txStartCount++;
        if (done) doneCount++;
        if (timeout) timeoutCount++;
        if (done && timeout) bothSeen = 1;
    end

    // Hard stop in case the sequencer hangs somewhere unexpected.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        @(negedge clk);
        aIn   = a;
        bIn   = b;
        opIn  = op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for one byte, check it, acknowledge it ten cycles after its start pulse.
    task automatic txByte(input int idx, input logic [7:0] expByte, input bit injectRx, input bit injectStart);
        int waited;
        int doneSnap;
        waited   = 0;
        doneSnap = doneCount;
        do begin
            @(negedge clk);
            waited++;
        end while (!txStart && waited < 40);
        checkOutput($sformatf("txStart%0d_seen", idx), txStart, 1);
        if (idx == 0) checkOutput("startLatency", waited, 1);
        checkOutput($sformatf("txData%0d", idx), txData, expByte);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) checkOutput($sformatf("txStart%0d_width", idx), txStart, 0);
            if (c == 3) begin
                doneSnap = doneCount;
                if (injectRx) begin
                    rxData = 8'hAA;
                    rxDone = 1'b1;
                end
                if (injectStart) begin
                    aIn   = 8'hFF;
                    bIn   = 8'h00;
                    opIn  = 6'h00;
                    start = 1'b1;
                end
            end
            if (c == 4) begin
                rxDone = 1'b0;
                start  = 1'b0;
            end
            if (c == 5 && injectRx) begin
                checkOutput("rxIgnored_result", result, lastResult);
                checkOutput("rxIgnored_done", doneCount, doneSnap);
            end
        end
        checkOutput($sformatf("txData%0d_hold", idx), txData, expByte);
        checkOutput($sformatf("busy%0d", idx), busy, 1);
        txDone = 1'b1;
        @(negedge clk);
        txDone = 1'b0;
    endtask

    // Deliver a result byte in RX_WAIT and check the single o_done pulse.
    task automatic deliverResult(input string tag, input logic [7:0] rxByte);
        rxData = rxByte;
        rxDone = 1'b1;
        @(negedge clk);
        rxDone = 1'b0;
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_result"}, result, rxByte);
        checkOutput({tag, "_idle"}, busy, 0);
        @(negedge clk);
        checkOutput({tag, "_doneWidth"}, done, 0);
        checkOutput({tag, "_resultHeld"}, result, rxByte);
        lastResult = rxByte;
    endtask

    task automatic runSequence(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                               input bit injRx, input bit injStart);
        logic [7:0] seq [7];
        seq[0] = 8'h01;
        seq[1] = a;
        seq[2] = 8'h02;
        seq[3] = b;
        seq[4] = 8'h03;
        seq[5] = {2'b00, op};
        seq[6] = 8'h00;
        applyStimulus(a, b, op);
        for (int i = 0; i < 7; i++) begin
            txByte(i, seq[i], injRx && (i == 2), injStart && (i == 0));
        end
    endtask

    initial begin
        int waited;
        int startSnap;
        int doneSnap;
        int toSnap;
        rst    = 1'b1;
        start  = 1'b0;
        aIn    = 8'h00;
        bIn    = 8'h00;
        opIn   = 6'h00;
        txDone = 1'b0;
        rxData = 8'h00;
        rxDone = 1'b0;

        // Reset values.
        @(negedge clk);
        checkOutput("rst_txStart", txStart, 0);
        checkOutput("rst_txData", txData, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_timeout", timeout, 0);
        checkOutput("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Basic transaction: 5, 3, op 0x20, result 0x08.
        runSequence(8'h05, 8'h03, 6'h20, 1'b0, 1'b0);
        deliverResult("basic", 8'h08);
        checkOutput("basic_doneCount", doneCount, 1);

        // Stray rx byte during TX_WAIT must be ignored.
        runSequence(8'hC1, 8'h1C, 6'h0A, 1'b1, 1'b0);
        deliverResult("strayRx", 8'h11);
        checkOutput("strayRx_doneCount", doneCount, 2);

        // i_start with A=0xFF during TX_WAIT must not disturb the captured operands.
        runSequence(8'h12, 8'h34, 6'h3F, 1'b0, 1'b1);
        deliverResult("lateStart", 8'h9D);

        // Reset after the third byte's start pulse aborts the transaction.
        applyStimulus(8'h33, 8'h44, 6'h15);
        txByte(0, 8'h01, 1'b0, 1'b0);
        txByte(1, 8'h33, 1'b0, 1'b0);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!txStart && waited < 40);
        checkOutput("abort_txStart2", txStart, 1);
        checkOutput("abort_txData2", txData, 8'h02);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_txStart", txStart, 0);
        checkOutput("abort_txData", txData, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_timeout", timeout, 0);
        checkOutput("abort_busy", busy, 0);
        lastResult = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        startSnap = txStartCount;
        doneSnap  = doneCount;
        toSnap    = timeoutCount;
        repeat (5) @(negedge clk);
        txDone = 1'b1;
        rxDone = 1'b1;
        rxData = 8'hEE;
        @(negedge clk);
        txDone = 1'b0;
        rxDone = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("abort_noTxStart", txStartCount, startSnap);
        checkOutput("abort_noDone", doneCount, doneSnap);
        checkOutput("abort_noTimeout", timeoutCount, toSnap);
        checkOutput("abort_resultZero", result, 0);
        checkOutput("abort_idle", busy, 0);

        // A fresh transaction after the abort runs the full sequence.
        runSequence(8'h7E, 8'h81, 6'h01, 1'b0, 1'b0);
        deliverResult("afterAbort", 8'hC3);

        // Silent receiver: watchdog fires, or the block waits indefinitely.
        runSequence(8'h0F, 8'hF0, 6'h2A, 1'b0, 1'b0);
        doneSnap = doneCount;
`ifdef ALU_CMD_MASTER_TIMEOUT_EN
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!timeout && waited < 200);
        checkOutput("wd_pulse", timeout, 1);
        checkOutput("wd_latency", waited, 100);
        checkOutput("wd_resultKept", result, lastResult);
        checkOutput("wd_idle", busy, 0);
        checkOutput("wd_noDone", done, 0);
        @(negedge clk);
        checkOutput("wd_width", timeout, 0);
        checkOutput("wd_doneCount", doneCount, doneSnap);
`else
        repeat (150) @(negedge clk);
        checkOutput("noWd_busy", busy, 1);
        checkOutput("noWd_timeoutCount", timeoutCount, 0);
        checkOutput("noWd_doneCount", doneCount, doneSnap);
        deliverResult("noWd", 8'h5A);
`endif

        checkOutput("doneTimeoutExclusive", bothSeen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
        $finish;
    end

endmodule
